bb_clk_div_multi: RTL
=====================

// Module: bb_clk_div_multi
// PURPOSE
//  Parametrised multi-channel clock divider in the baseband block; derives NUM_CH
//  divided clocks (MSI001, QN8027, spare) from clk_48mhz. Per channel: enable,
//  divide ratio, and a matching one-cycle tick strobe. Ratio changes take effect
//  only at period boundaries, so there are no runt pulses. Optional phase alignment
//  restarts all channels together. Defaults reproduce the 24 MHz baseline (div 2).
// PARAMETERS
//  NUM_CH       2   number of divided-clock channels (1..8)
//  DIV_W        8   width of divide ratio; legal ratio 2..2**DIV_W-1
//  DEFAULT_DIV  2   ratio loaded into every channel at reset
//  CH_W         (NUM_CH>1 ? $clog2(NUM_CH) : 1)  localparam, cfg_ch width
// PORTS
//  clk_48mhz  in   1       48 MHz system clock
//  rstn       in   1       async active-low reset
//  ch_en      in   NUM_CH  per-channel run enable (level, sync to clk_48mhz)
//  align_req  in   1       1-cycle pulse: restart all running channels in phase
//  cfg_wr     in   1       1-cycle config write strobe
//  cfg_ch     in   CH_W    channel index for cfg_wr
//  cfg_div    in   DIV_W   new divide ratio N for cfg_ch
//  cfg_ack    out  1       1-cycle pulse, cycle after a legal cfg_wr
//  cfg_err    out  1       1-cycle pulse, cycle after an illegal cfg_wr
//  clk_out    out  NUM_CH  registered divided clocks
//  tick       out  NUM_CH  1-cycle pulse, coincident with clk_out rising
// BEHAVIOUR
//  Reset: already decided -- reset rstn, asynchronous, active-low; clock clk_48mhz.
//   All outputs 0; every channel IDLE, div_act=div_pend=DEFAULT_DIV, cnt=0.
//  Per channel: cnt 0..div_act-1; clk_out=1 while cnt < div_act>>1, else 0.
//   High floor(N/2) cycles, low ceil(N/2). N=2: 1/1; N=3: 1/2; N=4: 2/2.
//  States: IDLE (clk_out=0, cnt=0), RUN, STOP.
//   IDLE->RUN when ch_en=1: cnt=0 and clk_out=1 from the next edge. tick=1 that cycle.
//   RUN->STOP when ch_en=0 and cnt!=div_act-1. STOP finishes the period, then IDLE.
//   RUN->IDLE directly when ch_en=0 and cnt==div_act-1.
//   STOP->RUN if ch_en returns high before the boundary (no gap, period continues).
//  Config write:
//   Legal: cfg_ch<NUM_CH and cfg_div>=2. Loads div_pend and sets pend flag.
//   Illegal: nothing changes; cfg_err pulses.
//   pend is applied at the boundary (cnt==div_act-1 -> wrap to 0), or at once in IDLE.
//   A second write before the boundary overwrites div_pend; the last write wins.
//   Each write still gets its own ack.
//  Tick: tick=1 exactly on the cycles where cnt wraps to 0 (rising edge of clk_out).
//  align_req: every channel in RUN/STOP loads cnt=0 next cycle (clk_out=1, tick=1).
//   Pending ratios are applied at that point. IDLE channels are unaffected.
//   align_req wins over a simultaneous normal wrap. A cfg_wr in the same cycle
//   applies immediately.
//  Wrap: cnt is DIV_W bits and never exceeds div_act-1; no overflow path.
//  Reset mid-operation: outputs drop to 0 asynchronously; ratios revert to DEFAULT_DIV.
//  Latency: cfg_wr -> ack 1 cycle; ch_en -> first clk_out edge 1 cycle.
//  clk_out is a registered clock-like output for pads and external chips only.
//  Internal logic must use tick as a clock enable, never clk_out as a clock.
// STRUCTURE
//  Package bb_clk_pkg:
//   MIN_DIV=2
//   typedef enum {CH_IDLE, CH_RUN, CH_STOP} ch_state_t
//   Default DIV_W constant
//  Sub-module bb_clk_div_ch: one channel (FSM, counter, div_act/div_pend, outputs).
//   Instantiated NUM_CH times via generate.
//  Top level: cfg decode/validation, ack/err pulses, align_req fan-out.
// TESTING
//  1 Reset, ch_en=2'b11, no cfg -> both clk_out 1/0 toggling (24 MHz).
//    tick every 2nd cycle; first rise 1 cycle after ch_en.
//  2 ch1 running N=2, cfg_wr ch1 N=4 mid-period -> ack next cycle.
//    New 2-high/2-low starts at the next wrap; no pulse shorter than 1 cycle.
//  3 cfg_div=3 on ch0 -> high 1, low 2, tick period 3.
//    cfg_div=1, or cfg_ch=NUM_CH -> cfg_err pulse, ratio unchanged, no ack.
//  4 Drop ch_en while ch0 N=6 at cnt=1 -> period completes (cnt 5), then low/IDLE.
//    Re-enable at cnt=3 -> continues without gap.
//  5 ch0 N=4, ch1 N=6 free-running, pulse align_req -> both tick and rise the same
//    next cycle. An IDLE third channel stays low.
//  6 Assert rstn=0 mid-high with a pending write -> clk_out/tick 0 immediately.
//    After release and enable, period=DEFAULT_DIV.

Source files
------------

// File: rtl/bb_clk_pkg.sv
// bb_clk_pkg
// Shared definitions for the baseband multi-channel clock divider.
//   MIN_DIV        smallest legal divide ratio
//   DEFAULT_DIV_W  default width of the divide-ratio field
//   ch_state_t     per-channel run state
package bb_clk_pkg;

    localparam int MIN_DIV       = 2;
    localparam int DEFAULT_DIV_W = 8;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_STOP = 2'd2
    } ch_state_t;

endpackage

// File: rtl/bb_clk_div_ch.sv
// bb_clk_div_ch
// One divided-clock channel: run FSM, period counter, active/pending ratio.
// Ports:
//   clk_48mhz  in   system clock
//   rstn       in   async active-low reset
//   en         in   run enable (level)
//   align      in   restart the period now if running or stopping
//   wr         in   validated config write for this channel
//   wr_div     in   ratio carried by wr
//   clk_out    out  registered divided clock (high floor(N/2), low ceil(N/2))
//   tick       out  one-cycle pulse on every clk_out rising edge
module bb_clk_div_ch
    import bb_clk_pkg::*;
#(
    parameter int DIV_W       = DEFAULT_DIV_W,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk_48mhz,
    input  logic             rstn,
    input  logic             en,
    input  logic             align,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick
);

    ch_state_t        state_reg, state_next;
    logic [DIV_W-1:0] cnt_reg, cnt_next;
    logic [DIV_W-1:0] div_act_reg, div_act_next;
    logic [DIV_W-1:0] div_pend_reg, div_pend_next;
    logic             pend_reg, pend_next;
    logic             clk_reg, clk_next;
    logic             tick_reg, tick_next;

    logic             at_end;
    logic             apply;
    logic             restart;
    logic             eff_pend;
    logic [DIV_W-1:0] eff_div;

    always_ff @(posedge clk_48mhz or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= CH_IDLE;
            cnt_reg      <= '0;
            div_act_reg  <= DIV_W'(DEFAULT_DIV);
            div_pend_reg <= DIV_W'(DEFAULT_DIV);
            pend_reg     <= 1'b0;
            clk_reg      <= 1'b0;
            tick_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            div_act_reg  <= div_act_next;
            div_pend_reg <= div_pend_next;
            pend_reg     <= pend_next;
            clk_reg      <= clk_next;
            tick_reg     <= tick_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        div_act_next  = div_act_reg;
        div_pend_next = div_pend_reg;
        pend_next     = pend_reg;
        tick_next     = 1'b0;
        clk_next      = 1'b0;
        apply         = 1'b0;
        restart       = 1'b0;

        at_end = (cnt_reg == div_act_reg - 1'b1);

        // A write in the same cycle as an apply point takes effect right
        // away, so fold it into the pending view used below.
        eff_pend = wr | pend_reg;
        eff_div  = wr ? wr_div : div_pend_reg;

        if (wr) begin
            div_pend_next = wr_div;
            pend_next     = 1'b1;
        end

        case (state_reg)
            CH_IDLE: begin
                apply    = 1'b1;
                cnt_next = '0;
                if (en) begin
                    state_next = CH_RUN;
                    restart    = 1'b1;
                end
            end
            CH_RUN, CH_STOP: begin
                if (align) begin
                    // Alignment beats a coincident natural wrap.
                    apply      = 1'b1;
                    restart    = 1'b1;
                    state_next = en ? CH_RUN : CH_STOP;
                end else if (at_end) begin
                    apply = 1'b1;
                    if (en) begin
                        restart    = 1'b1;
                        state_next = CH_RUN;
                    end else begin
                        cnt_next   = '0;
                        state_next = CH_IDLE;
                    end
                end else begin
                    // Mid-period: keep counting; a dropped enable only
                    // parks the FSM in STOP so the period completes.
                    cnt_next   = cnt_reg + 1'b1;
                    state_next = en ? CH_RUN : CH_STOP;
                end
            end
            default: begin
                state_next = CH_IDLE;
                cnt_next   = '0;
            end
        endcase

        if (apply && eff_pend) begin
            div_act_next  = eff_div;
            div_pend_next = eff_div;
            pend_next     = 1'b0;
        end

        if (restart) begin
            cnt_next  = '0;
            tick_next = 1'b1;
        end

        clk_next = (state_next != CH_IDLE) && (cnt_next < (div_act_next >> 1));
    end

    assign clk_out = clk_reg;
    assign tick    = tick_reg;

endmodule

// File: rtl/bb_clk_div_multi.sv
// bb_clk_div_multi
// Multi-channel clock divider deriving NUM_CH divided clocks from clk_48mhz.
// clk_out is a pad/chip-facing clock only; internal logic must use tick as a
// clock enable.
// Ports:
//   clk_48mhz  in   48 MHz system clock
//   rstn       in   async active-low reset
//   ch_en      in   per-channel run enable
//   align_req  in   pulse: restart all running channels in phase
//   cfg_wr     in   config write strobe
//   cfg_ch     in   channel index for cfg_wr
//   cfg_div    in   new divide ratio for cfg_ch
//   cfg_ack    out  pulse, cycle after a legal write
//   cfg_err    out  pulse, cycle after an illegal write
//   clk_out    out  registered divided clocks
//   tick       out  pulse coincident with each clk_out rising edge
module bb_clk_div_multi
    import bb_clk_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  DIV_W       = DEFAULT_DIV_W,
    parameter int  DEFAULT_DIV = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_48mhz,
    input  logic              rstn,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              align_req,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick
);

    logic              cfg_legal;
    logic [NUM_CH-1:0] ch_wr;
    logic              ack_reg;
    logic              err_reg;

    // Channel index may exceed NUM_CH when NUM_CH is not a power of two.
    assign cfg_legal = (int'(cfg_ch) < NUM_CH) && (cfg_div >= DIV_W'(MIN_DIV));

    always_ff @(posedge clk_48mhz or negedge rstn) begin
        if (!rstn) begin
            ack_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            ack_reg <= cfg_wr & cfg_legal;
            err_reg <= cfg_wr & ~cfg_legal;
        end
    end

    assign cfg_ack = ack_reg;
    assign cfg_err = err_reg;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        assign ch_wr[gi] = cfg_wr && cfg_legal && (int'(cfg_ch) == gi);

        bb_clk_div_ch #(
            .DIV_W       (DIV_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .clk_48mhz (clk_48mhz),
            .rstn      (rstn),
            .en        (ch_en[gi]),
            .align     (align_req),
            .wr        (ch_wr[gi]),
            .wr_div    (cfg_div),
            .clk_out   (clk_out[gi]),
            .tick      (tick[gi])
        );
    end

endmodule
